pipe_hazard_sched: RTL and testbench

- Central stall/flush/exception sequencer for the five-stage MIPS pipeline.
- Generates write-enable, flush and exception-request controls for the F/D pipeline register, the PC and the D/E register.
- Owns the multiply/divide busy timer, so MDU-dependent instructions stall in D.
- Arbitrates priority between exception entry, eret redirect, data-hazard stalls and MDU stalls.

---
 rtl/pipe_hazard_sched.sv | 113 +++++++++++
 tb/tb_pipe_hazard_sched.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_sched.sv
// Stall/flush/exception sequencer for the five-stage pipeline.
// Drives the F/D, PC and D/E register controls and owns the MDU busy timer.
// Exception entry outranks a data/MDU stall, which outranks eret.
module pipe_hazard_sched #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_data,
    input  logic        D_is_md,
    input  logic        D_eret,
    input  logic        E_md_start,
    input  logic        E_md_div,
    input  logic        exc_req,
    output logic        pc_wren,
    output logic        fd_wren,
    output logic        fd_flush,
    output logic        req,
    output logic        de_clear,
    output logic        md_busy,
    output logic        pc_sel_eret,
    output logic [31:0] pc_next_exc,
    output logic [7:0]  exc_count
);

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] EXC  = 2'd1;
    localparam logic [1:0] ERET = 2'd2;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

    logic [1:0] state_q, state_d;
    logic [3:0] md_cnt_q, md_cnt_d;
    logic [7:0] exc_cnt_q, exc_cnt_d;
    logic       req_acc;
    logic       md_start_acc;
    logic       stall;

    assign pc_next_exc = EXC_VEC;

    // Request acceptance: exc_req is masked for the one cycle after entry.
    always_comb begin
        req_acc      = ~reset & exc_req & (state_q != EXC);
        // A start alongside req belongs to the instruction being killed.
        md_start_acc = ~reset & E_md_start & ~req_acc;
        md_busy      = ~reset & ((md_cnt_q != 4'd0) | md_start_acc);
        stall        = stall_data | (D_is_md & md_busy);
        exc_count    = reset ? 8'd0 : exc_cnt_q;
    end

    // MDU timer and saturating exception counter next state.
    always_comb begin
        md_cnt_d  = md_cnt_q;
        exc_cnt_d = exc_cnt_q;
        if (md_start_acc) begin
            md_cnt_d = E_md_div ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end
        if (req_acc && exc_cnt_q != 8'hff) begin
            exc_cnt_d = exc_cnt_q + 8'd1;
        end
    end

    // Prioritised pipeline controls and FSM next state.
    always_comb begin
        pc_wren     = 1'b0;
        fd_wren     = 1'b0;
        fd_flush    = 1'b0;
        req         = 1'b0;
        de_clear    = 1'b0;
        pc_sel_eret = 1'b0;
        state_d     = RUN;
        if (reset) begin
            state_d = RUN;
        end else if (req_acc) begin
            req     = 1'b1;
            pc_wren = 1'b1;
            state_d = EXC;
        end else if (stall) begin
            // RUN holds; EXC and ERET are single-cycle and fall back to RUN.
            de_clear = 1'b1;
            state_d  = RUN;
        end else if (D_eret && state_q != ERET) begin
            // In ERET, D holds the flushed delay slot, so its eret is stale.
            pc_sel_eret = 1'b1;
            pc_wren     = 1'b1;
            fd_wren     = 1'b1;
            fd_flush    = 1'b1;
            state_d     = ERET;
        end else begin
            pc_wren = 1'b1;
            fd_wren = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            md_cnt_q  <= 4'd0;
            exc_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            md_cnt_q  <= md_cnt_d;
            exc_cnt_q <= exc_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Directed table-driven bench for pipe_hazard_sched.
module tb_pipe_hazard_sched;

    logic        clk = 1'b0;
    logic        reset, stall_data, D_is_md, D_eret, E_md_start, E_md_div, exc_req;
    logic        pc_wren, fd_wren, fd_flush, req, de_clear, md_busy, pc_sel_eret;
    logic [31:0] pc_next_exc;
    logic [7:0]  exc_count;

    pipe_hazard_sched dut (
        .clk         (clk),
        .reset       (reset),
        .stall_data  (stall_data),
        .D_is_md     (D_is_md),
        .D_eret      (D_eret),
        .E_md_start  (E_md_start),
        .E_md_div    (E_md_div),
        .exc_req     (exc_req),
        .pc_wren     (pc_wren),
        .fd_wren     (fd_wren),
        .fd_flush    (fd_flush),
        .req         (req),
        .de_clear    (de_clear),
        .md_busy     (md_busy),
        .pc_sel_eret (pc_sel_eret),
        .pc_next_exc (pc_next_exc),
        .exc_count   (exc_count)
    );

    always #5 clk = ~clk;

    // Inputs  {reset, stall_data, D_is_md, D_eret, E_md_start, E_md_div, exc_req}
    // Outputs {pc_wren, fd_wren, fd_flush, req, de_clear, md_busy, pc_sel_eret}
    typedef struct {
        logic [6:0] in;
        logic [6:0] out;
        logic [7:0] cnt;
    } vec_t;

    localparam logic [6:0] I_RST  = 7'b1000000;
    localparam logic [6:0] I_STL  = 7'b0100000;
    localparam logic [6:0] I_MD   = 7'b0010000;
    localparam logic [6:0] I_ERET = 7'b0001000;
    localparam logic [6:0] I_ST   = 7'b0000100;
    localparam logic [6:0] I_DIV  = 7'b0000010;
    localparam logic [6:0] I_EXC  = 7'b0000001;
    localparam logic [6:0] I_IDLE = 7'b0000000;

    localparam logic [6:0] O_ZERO = 7'b0000000;
    localparam logic [6:0] O_RUN  = 7'b1100000;
    localparam logic [6:0] O_RUNB = 7'b1100010;
    localparam logic [6:0] O_STLB = 7'b0000110;
    localparam logic [6:0] O_STL  = 7'b0000100;
    localparam logic [6:0] O_REQ  = 7'b1001000;
    localparam logic [6:0] O_ERET = 7'b1110001;

    vec_t vec[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic [6:0] i, input logic [6:0] o, input logic [7:0] c);
        vec_t v;
        v.in  = i;
        v.out = o;
        v.cnt = c;
        vec.push_back(v);
    endtask

    // Drive one cycle of inputs after the falling edge; outputs settle before the rise.
    task automatic drive(input logic [6:0] i);
        @(negedge clk);
        {reset, stall_data, D_is_md, D_eret, E_md_start, E_md_div, exc_req} = i;
        #1;
    endtask

    task automatic check(input string name, input logic [6:0] o, input logic [7:0] c);
        logic [6:0] act;
        act = {pc_wren, fd_wren, fd_flush, req, de_clear, md_busy, pc_sel_eret};
        n_vec++;
        if (act !== o || exc_count !== c || (fd_flush & req)) begin
            n_bad++;
            $display("FAIL %s: ctl=%b cnt=%0d, required ctl=%b cnt=%0d", name, act, exc_count,
                     o, c);
        end
    endtask

    initial begin
        {reset, stall_data, D_is_md, D_eret, E_md_start, E_md_div, exc_req} = I_RST;

        // Reset, idle
        add(I_RST, O_ZERO, 0);
        add(I_RST, O_ZERO, 0);
        for (int k = 0; k < 3; k++) add(I_IDLE, O_RUN, 0);
        // mult start, D_is_md held: stall cycles 1..5
        add(I_ST, O_RUNB, 0);
        for (int k = 0; k < 5; k++) add(I_MD, O_STLB, 0);
        add(I_MD, O_RUN, 0);
        // div start: stall cycles 1..10
        add(I_ST | I_DIV, O_RUNB, 0);
        for (int k = 0; k < 10; k++) add(I_MD, O_STLB, 0);
        add(I_MD, O_RUN, 0);
        // exc with stall and MDU start: req wins, start dropped
        add(I_EXC | I_STL | I_ST, O_REQ, 0);
        add(I_IDLE, O_RUN, 1);
        // exc held three cycles: req on first and third
        add(I_EXC, O_REQ, 1);
        add(I_EXC, O_RUN, 2);
        add(I_EXC, O_REQ, 2);
        add(I_IDLE, O_RUN, 3);
        add(I_IDLE, O_RUN, 3);
        // eret under stall, then release, then held in ERET
        add(I_ERET | I_STL, O_STL, 3);
        add(I_ERET | I_STL, O_STL, 3);
        add(I_ERET, O_ERET, 3);
        add(I_ERET, O_RUN, 3);
        add(I_IDLE, O_RUN, 3);
        // exc wins in ERET
        add(I_ERET, O_ERET, 3);
        add(I_EXC, O_REQ, 3);
        add(I_IDLE, O_RUN, 4);
        // exc over eret, then eret allowed from EXC
        add(I_EXC | I_ERET, O_REQ, 4);
        add(I_ERET, O_ERET, 5);
        add(I_IDLE, O_RUN, 5);
        // reset while MDU busy
        add(I_ST, O_RUNB, 5);
        add(I_MD, O_STLB, 5);
        add(I_RST | I_MD, O_ZERO, 0);
        add(I_MD, O_RUN, 0);

        foreach (vec[k]) begin
            drive(vec[k].in);
            check($sformatf("vec%0d", k), vec[k].out, vec[k].cnt);
        end

        n_vec++;
        if (pc_next_exc !== 32'h0000_4180) begin
            n_bad++;
            $display("FAIL pc_next_exc: got %h, required %h", pc_next_exc, 32'h0000_4180);
        end

        // 300 separated exceptions saturate the counter
        for (int k = 0; k < 300; k++) begin
            drive(I_EXC);
            drive(I_IDLE);
        end
        check("sat_300", O_RUN, 8'd255);
        drive(I_EXC);
        check("sat_req", O_REQ, 8'd255);
        drive(I_IDLE);
        check("sat_hold", O_RUN, 8'd255);
        drive(I_RST);
        check("sat_reset", O_ZERO, 8'd0);
        drive(I_IDLE);
        check("post_reset", O_RUN, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
